// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared board geometry, cell-id encoding, coordinate type and the
// row_checker state encoding. Imported by row_checker, board_scan_counter
// and the clear_row logic that consumes row_checker results.
// No ports (package).
// -----------------------------------------------------------------------------
package tetris_pkg;

  // Board geometry: x = 0..BOARD_W-1, y = 0 (top) .. BOARD_H-1 (bottom)
  localparam int BOARD_W   = 10;
  localparam int BOARD_H   = 20;
  // Rows 0..FAIL_ROWS-1 are the spawn zone
  localparam int FAIL_ROWS = 2;
  // Cell id width; id 0 marks an empty cell
  localparam int ID_W      = 3;
  localparam logic [ID_W-1:0] EMPTY_ID = 3'd0;
  // Coordinates are 5 bits, so the board is limited to 32x32
  localparam int COORD_W   = 5;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_SCAN  = 2'd1,
    RC_DRAIN = 2'd2,
    RC_DONE  = 2'd3
  } rc_state_t;

endpackage : tetris_pkg

// File: rtl/board_scan_counter.sv
// -----------------------------------------------------------------------------
// board_scan_counter
// Walks the board bottom-up in raster order: x counts 0..WIDTH-1 and wraps,
// y decrements on each wrap and saturates at 0. Also used by clear_row's
// shift-down pass.
//
// Ports:
//   i_clk     in   system clock
//   i_rst     in   synchronous active-high reset (x=0, y=0)
//   i_clear   in   load the start position (0, HEIGHT-1); wins over i_enable
//   i_enable  in   advance one position
//   o_x       out  current column (registered)
//   o_y       out  current row (registered)
//   o_last    out  high while the position is (WIDTH-1, 0)
// -----------------------------------------------------------------------------
module board_scan_counter #(
  parameter int WIDTH  = tetris_pkg::BOARD_W,
  parameter int HEIGHT = tetris_pkg::BOARD_H
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_enable,
  output logic [4:0] o_x,
  output logic [4:0] o_y,
  output logic       o_last
);
  import tetris_pkg::*;

  localparam coord_t X_LAST  = coord_t'(WIDTH - 1);
  localparam coord_t Y_START = coord_t'(HEIGHT - 1);

  coord_t r_x;
  coord_t r_y;

  // Position register: reset, load start, or advance in raster order
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= 5'd0;
      r_y <= 5'd0;
    end else if (i_clear) begin
      r_x <= 5'd0;
      r_y <= Y_START;
    end else if (i_enable) begin
      if (r_x == X_LAST) begin
        r_x <= 5'd0;
        // y saturates at the top row instead of wrapping to 31
        if (r_y != 5'd0) begin
          r_y <= r_y - 5'd1;
        end else begin
          r_y <= r_y;
        end
      end else begin
        r_x <= r_x + 5'd1;
        r_y <= r_y;
      end
    end else begin
      r_x <= r_x;
      r_y <= r_y;
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == X_LAST) && (r_y == 5'd0);

endmodule : board_scan_counter

// File: rtl/row_checker.sv
// -----------------------------------------------------------------------------
// row_checker
// After a piece locks, scans the board RAM bottom-up through its read port
// and reports the first full row, or game over if no row is full and the
// spawn zone holds any occupied cell. Feeds clear_row.
//
// Ports:
//   i_clk            in   system clock
//   i_rst            in   synchronous active-high reset
//   i_start_check    in   one-cycle scan request (ignored while scanning)
//   i_read_id        in   board RAM read data, one cycle after the address
//   o_read_x         out  board RAM read column (registered)
//   o_read_y         out  board RAM read row (registered)
//   o_busy           out  high while scanning
//   o_result_valid   out  high from completion until next start or reset
//   o_fail_or_full   out  o_full | o_fail
//   o_full           out  a full row was found
//   o_fail           out  no full row and the spawn zone is occupied
//   o_row            out  y of the first full row bottom-up, 0 if none
// -----------------------------------------------------------------------------
module row_checker #(
  parameter int WIDTH     = tetris_pkg::BOARD_W,
  parameter int HEIGHT    = tetris_pkg::BOARD_H,
  parameter int FAIL_ROWS = tetris_pkg::FAIL_ROWS,
  parameter int ID_W      = tetris_pkg::ID_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start_check,
  input  logic [ID_W-1:0] i_read_id,
  output logic [4:0]      o_read_x,
  output logic [4:0]      o_read_y,
  output logic            o_busy,
  output logic            o_result_valid,
  output logic            o_fail_or_full,
  output logic            o_full,
  output logic            o_fail,
  output logic [4:0]      o_row
);
  import tetris_pkg::*;

  localparam coord_t X_LAST      = coord_t'(WIDTH - 1);
  localparam coord_t SPAWN_LIMIT = coord_t'(FAIL_ROWS);

  rc_state_t r_state;

  // Address of the datum currently on i_read_id (address issued last cycle)
  coord_t r_tag_x;
  coord_t r_tag_y;
  logic   r_tag_valid;

  // Running AND over the current row and OR over the spawn zone
  logic   r_row_all;
  logic   r_spawn_hit;

  logic   w_accept_start;
  logic   w_enable;
  logic   w_last;
  coord_t w_x;
  coord_t w_y;
  logic   w_occupied;
  logic   w_row_all_next;
  logic   w_spawn_next;
  logic   w_full_hit;

  board_scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_accept_start),
    .i_enable (w_enable),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_last   (w_last)
  );

  assign o_read_x = w_x;
  assign o_read_y = w_y;

  // Evaluate the returning datum against the per-row and spawn accumulators
  always_comb begin
    w_accept_start = i_start_check &&
                     ((r_state == RC_IDLE) || (r_state == RC_DONE));
    // Stop advancing once the final address is out; the counter then holds
    w_enable       = (r_state == RC_SCAN) && !w_last;
    w_occupied     = (i_read_id != EMPTY_ID);

    // Column 0 starts a fresh row, so the accumulator restarts from 1
    if (r_tag_x == 5'd0) begin
      w_row_all_next = w_occupied;
    end else begin
      w_row_all_next = r_row_all & w_occupied;
    end

    if (r_tag_valid && (r_tag_y < SPAWN_LIMIT)) begin
      w_spawn_next = r_spawn_hit | w_occupied;
    end else begin
      w_spawn_next = r_spawn_hit;
    end

    w_full_hit = r_tag_valid && (r_tag_x == X_LAST) && w_row_all_next;
  end

  // Scan control FSM with registered result outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= RC_IDLE;
      r_tag_x        <= 5'd0;
      r_tag_y        <= 5'd0;
      r_tag_valid    <= 1'b0;
      r_row_all      <= 1'b1;
      r_spawn_hit    <= 1'b0;
      o_busy         <= 1'b0;
      o_result_valid <= 1'b0;
      o_fail_or_full <= 1'b0;
      o_full         <= 1'b0;
      o_fail         <= 1'b0;
      o_row          <= 5'd0;
    end else begin
      case (r_state)
        RC_IDLE, RC_DONE: begin
          if (i_start_check) begin
            r_state        <= RC_SCAN;
            r_tag_valid    <= 1'b0;
            r_row_all      <= 1'b1;
            r_spawn_hit    <= 1'b0;
            o_busy         <= 1'b1;
            o_result_valid <= 1'b0;
            o_fail_or_full <= 1'b0;
            o_full         <= 1'b0;
            o_fail         <= 1'b0;
            o_row          <= 5'd0;
          end else begin
            r_state <= r_state;
          end
        end

        RC_SCAN: begin
          // The address issued this cycle tags next cycle's read data
          r_tag_x     <= w_x;
          r_tag_y     <= w_y;
          r_tag_valid <= 1'b1;
          r_row_all   <= w_row_all_next;
          r_spawn_hit <= w_spawn_next;
          if (w_full_hit) begin
            // In-flight speculative reads are simply dropped
            r_state        <= RC_DONE;
            o_busy         <= 1'b0;
            o_result_valid <= 1'b1;
            o_full         <= 1'b1;
            o_fail         <= 1'b0;
            o_fail_or_full <= 1'b1;
            o_row          <= r_tag_y;
          end else if (w_last) begin
            r_state <= RC_DRAIN;
          end else begin
            r_state <= RC_SCAN;
          end
        end

        RC_DRAIN: begin
          // Final datum (WIDTH-1, 0) is on the read port this cycle
          r_state        <= RC_DONE;
          r_tag_valid    <= 1'b0;
          o_busy         <= 1'b0;
          o_result_valid <= 1'b1;
          if (w_full_hit) begin
            o_full         <= 1'b1;
            o_fail         <= 1'b0;
            o_fail_or_full <= 1'b1;
            o_row          <= r_tag_y;
          end else begin
            o_full         <= 1'b0;
            o_fail         <= w_spawn_next;
            o_fail_or_full <= w_spawn_next;
            o_row          <= 5'd0;
          end
        end

        default: begin
          r_state        <= RC_IDLE;
          r_tag_valid    <= 1'b0;
          o_busy         <= 1'b0;
          o_result_valid <= 1'b0;
          o_fail_or_full <= 1'b0;
          o_full         <= 1'b0;
          o_fail         <= 1'b0;
          o_row          <= 5'd0;
        end
      endcase
    end
  end

endmodule : row_checker

// File: tb/tb_row_checker.sv
module tb_row_checker;
  localparam int W  = 10;
  localparam int H  = 20;
  localparam int FR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] read_id = 3'd0;
  logic [4:0] read_x, read_y, row;
  logic       busy, result_valid, fail_or_full, full, fail;

  int checks = 0;
  int errors = 0;

  // Board RAM image, sized 32x32 so the 5-bit address indexes it directly
  logic [2:0] board [0:31][0:31];

  row_checker dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start_check  (start),
    .i_read_id      (read_id),
    .o_read_x       (read_x),
    .o_read_y       (read_y),
    .o_busy         (busy),
    .o_result_valid (result_valid),
    .o_fail_or_full (fail_or_full),
    .o_full         (full),
    .o_fail         (fail),
    .o_row          (row)
  );

  always #5 clk = ~clk;

  // Synchronous-read board RAM: data one cycle after the address
  always @(posedge clk) read_id <= board[read_y][read_x];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        board[y][x] = 3'd0;
  endtask

  task automatic fill_row(input int y, input logic [2:0] id);
    for (int x = 0; x < W; x++) board[y][x] = id;
  endtask

  // Reference: search rows bottom-up for one with no empty cell; otherwise
  // game over iff any spawn-zone cell is occupied.
  task automatic model_expect(output logic e_full, output logic e_fail,
                              output int e_row, output int e_lat);
    bit all;
    e_full = 1'b0; e_fail = 1'b0; e_row = 0; e_lat = W * H + 2;
    for (int k = 0; k < H; k++) begin
      all = 1'b1;
      for (int x = 0; x < W; x++)
        if (board[H-1-k][x] == 3'd0) all = 1'b0;
      if (all && !e_full) begin
        e_full = 1'b1; e_row = H - 1 - k; e_lat = (k + 1) * W + 2;
      end
    end
    if (!e_full)
      for (int y = 0; y < FR; y++)
        for (int x = 0; x < W; x++)
          if (board[y][x] != 3'd0) e_fail = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".rv"},   32'(result_valid), 32'd0);
    chk({tag, ".fof"},  32'(fail_or_full), 32'd0);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".fail"}, 32'(fail), 32'd0);
    chk({tag, ".row"},  32'(row), 32'd0);
    chk({tag, ".rx"},   32'(read_x), 32'd0);
    chk({tag, ".ry"},   32'(read_y), 32'd0);
  endtask

  // Called #1 after a posedge. start is high in cycle 0; pulse_at > 0 adds a
  // second start pulse in that cycle while the scan runs.
  task automatic run_scan(input string tag, input int pulse_at);
    logic e_full, e_fail;
    int   e_row, e_lat, cyc, busy_cnt;
    model_expect(e_full, e_fail, e_row, e_lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, ".c1_rv"},   32'(result_valid), 32'd0);
    chk({tag, ".c1_full"}, 32'(full), 32'd0);
    chk({tag, ".c1_rx"},   32'(read_x), 32'd0);
    chk({tag, ".c1_ry"},   32'(read_y), 32'(H - 1));
    busy_cnt = 0;
    while (result_valid !== 1'b1 && cyc < 400) begin
      if (busy === 1'b1) busy_cnt++;
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".latency"},  32'(cyc), 32'(e_lat));
    chk({tag, ".busy_cyc"}, 32'(busy_cnt), 32'(e_lat - 1));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".full"},     32'(full), 32'(e_full));
    chk({tag, ".fail"},     32'(fail), 32'(e_fail));
    chk({tag, ".fof"},      32'(fail_or_full), 32'(e_full | e_fail));
    chk({tag, ".row"},      32'(row), 32'(e_row));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".hold_rv"},  32'(result_valid), 32'd1);
    chk({tag, ".hold_fof"}, 32'(fail_or_full), 32'(e_full | e_fail));
    chk({tag, ".hold_row"}, 32'(row), 32'(e_row));
  endtask

  initial begin
    int cyc;
    clear_board();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty board
    run_scan("empty", 0);

    // Bottom row full
    fill_row(19, 3'd3);
    run_scan("row19", 0);

    // Rows 17 and 19 full; then clear 19 and rescan
    fill_row(17, 3'd5);
    run_scan("r17_19", 0);
    fill_row(19, 3'd0);
    run_scan("r17", 0);

    // Only row 5 full
    clear_board();
    fill_row(5, 3'd1);
    run_scan("row5", 0);

    // Full row wins over an occupied spawn zone
    clear_board();
    fill_row(18, 3'd7);
    board[0][4] = 3'd4;
    run_scan("r18_spawn", 0);

    // Spawn zone occupied, no full row
    clear_board();
    board[1][4] = 3'd2;
    run_scan("spawn", 0);

    // Reset in cycle 50 of a scan
    clear_board();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid.busy_c50", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle("mid_rst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.idle_busy", 32'(busy), 32'd0);
    chk("mid.idle_rv",   32'(result_valid), 32'd0);

    // Extra start pulse during SCAN must not restart the scan
    fill_row(12, 3'd6);
    run_scan("pulse_scan", 5);

    // Randomized boards
    for (int it = 0; it < 10; it++) begin
      clear_board();
      for (int y = 0; y < H; y++) begin
        if ($urandom_range(0, 9) == 0) begin
          for (int x = 0; x < W; x++) board[y][x] = 3'($urandom_range(1, 7));
        end else if (y < FR) begin
          for (int x = 0; x < W; x++)
            board[y][x] = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end else begin
          for (int x = 0; x < W; x++) board[y][x] = 3'($urandom_range(0, 7));
        end
      end
      run_scan($sformatf("rand%0d", it), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_row_checker
